spi_rr_master: RTL and testbench
================================

# spi_rr_master

Shared SPI master engine with a round-robin arbiter in front of it. Up to four on-chip requesters, each owning one slave select, submit single-byte transfers. The block grants the bus, generates SCK from the system clock, shifts the byte out and in, and returns the received byte with a completion pulse. It sits between the device logic and the external SPI pins, so no requester drives SCK, CS or MOSI directly.

## Interface
Parameters:
- N, 4: number of requesters, legal 2..4.
- CLK_DIV, 4: clk cycles per SCK half-period, legal ≥2.
- CS_GAP, 2: clk cycles with all cs_n high between released transactions, legal ≥1.

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-requester transfer request, level.
- p_data_in  in  8*N  transmit bytes; slice i is [8*i+7:8*i].
- lock  in  N  burst hold; only used when SPI_RR_LOCK_EN is defined.
- grant  out  N  one-hot owner of the bus.
- done  out  N  one-cycle pulse at transfer completion, to the owner.
- p_data_out  out  8  last received byte, valid from done onward.
- busy  out  1  high in every state except IDLE.
- sck  out  1  serial clock; CPOL=0.
- cs_n  out  N  active-low slave selects; cs_n[i] belongs to requester i.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- Bit order and edges:
  - LSB first.
  - MOSI changes on SCK falling edges and at CS assertion.
  - MISO is sampled on SCK rising edges.
- Round-robin pointer rr holds the last granted index; rr resets to N-1, so requester 0 wins first.
- IDLE: when any req bit is high, pick the first high bit searching rr+1, rr+2, … mod N. Then:
  - set grant and rr to that index;
  - drive cs_n[g] low;
  - load p_data_in slice g into the shift register;
  - drive mosi = bit0;
  - go to SETUP.
- SETUP: hold for CLK_DIV cycles, then go to SHIFT.
- SHIFT: sck toggles every CLK_DIV cycles, giving 8 rising and 8 falling edges.
  - On rising edge k, capture miso into rx[k].
  - On falling edges 1..7, drive bit k+1.
  - After falling edge 8 (sck=0), go to HOLD; mosi holds bit7.
- HOLD: hold for CLK_DIV cycles. In the last cycle, update p_data_out to rx and pulse done[g] for one cycle. Without a burst continuation:
  - set cs_n all high and grant to 0;
  - go to GAP.
- GAP: hold for CS_GAP cycles, then go to IDLE. Requests are not evaluated during GAP.
- Handshake and boundary rules:
  - A requester holds req and p_data_in stable until grant; data is captured only at grant.
  - Requester deasserts req on done or later. A req still high on re-entry to IDLE is a new request.
  - If req is dropped before grant, it is ignored.
  - If req is dropped after grant, the transfer still completes and done still pulses.
  - All inputs are sampled in the same cycle; N simultaneous requests are resolved purely by rr.
  - Only one cs_n is ever low; cs_n is never low outside SETUP/SHIFT/HOLD.

## Timing
- Reset values: sck=0, cs_n all 1, mosi=0, grant=0, done=0, p_data_out=0, busy=0, rr=N-1, state IDLE.
- rst_n low mid-transfer: all outputs go to reset values immediately (asynchronously). No done is issued, and the partial rx is discarded.
- Latency from request to grant: req high before clk edge t (in IDLE) gives grant, cs_n low and busy high after edge t.
- Grant to done: done is high in the cycle starting 18*CLK_DIV-1 edges after the grant edge. This covers CLK_DIV setup, 16*CLK_DIV shift and CLK_DIV hold.
- Back-to-back: minimum spacing between grants to different requesters is 18*CLK_DIV + CS_GAP + 1 cycles.

## Configuration
- SPI_RR_LOCK_EN defined: burst mode.
  - In HOLD, if lock[g] and req[g] are both high in the done cycle, cs_n[g] stays low and grant is kept.
  - The next p_data_in slice g is loaded, mosi = bit0, and the state returns to SETUP. GAP is skipped and rr does not advance.
  - Burst length is unbounded; fairness is the requester's responsibility.
- SPI_RR_LOCK_EN undefined: the lock input is ignored (left unconnected internally). Every byte releases CS and passes through GAP.

## Test plan
- Single transfer: N=4, CLK_DIV=2, req[0]=1, p_data_in slice0=8'hA5, miso looped from mosi.
  - mosi sequence 1,0,1,0,0,1,0,1.
  - done[0] pulse exactly 35 edges after grant; p_data_out=8'hA5.
  - cs_n=4'b1110 throughout.
- Fairness: req=4'b1111 held, each requester deasserting on its own done.
  - Grant order 0,1,2,3.
  - Then re-asserting req[0],req[2] after done gives order 0,2.
- MISO capture: slice1=8'h00, miso driven 8'h3C LSB-first, each bit changed on SCK falling edges → p_data_out=8'h3C at done[1].
- Reset mid-SHIFT: rst_n low after the 4th rising edge.
  - Outputs go to reset values without waiting for clk; no done.
  - Next request from requester 0 is granted first.
- Late drop: req[2] deasserted 3 cycles after grant → full 16 SCK edges still occur and done[2] pulses.
- Burst (SPI_RR_LOCK_EN): lock[1]=req[1]=1 for bytes 8'h01 then 8'h80, with req[0] also high.
  - cs_n[1] stays low across both bytes.
  - req[0] is granted only after the second done[1] plus CS_GAP.
  - Without the macro, req[0] is granted between the two bytes.

Source files
------------

// File: rtl/spi_rr_master.sv
// Shared SPI master (CPOL=0, LSB first) with a round-robin arbiter over N requesters.
// Define SPI_RR_LOCK_EN to enable burst mode (lock keeps CS low between bytes).
module spi_rr_master #(
  parameter int N       = 4,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] p_data_in,
  input  logic [N-1:0]   lock,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic [7:0]     p_data_out,
  output logic           busy,
  output logic           sck,
  output logic [N-1:0]   cs_n,
  output logic           mosi,
  input  logic           miso
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;
  logic [7:0]    pdo_q, pdo_d;
  logic          busy_q, busy_d;
  logic          sck_q, sck_d;
  logic [N-1:0]  cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;

  logic          found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;
  logic [7:0]    pick_byte;
  logic [7:0]    own_byte;

`ifndef SPI_RR_LOCK_EN
  logic lock_unused;
  assign lock_unused = ^lock;
`endif

  // Search starts one past the last owner, so rr alone decides ties.
  always_comb begin
    int j;
    j        = 0;
    found    = 1'b0;
    pick_idx = rr_q;
    for (int k = 1; k <= N; k++) begin
      j = (int'(rr_q) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        pick_idx = IW'(j);
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
    pick_byte         = p_data_in[8*int'(pick_idx) +: 8];
    own_byte          = p_data_in[8*int'(rr_q) +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    done_d  = '0;
    pdo_d   = pdo_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          cnt_d   = CW'(CLK_DIV - 1);
          bit_d   = 3'd0;
          rr_d    = pick_idx;
          grant_d = pick_oh;
          cs_n_d  = ~pick_oh;
          tx_d    = pick_byte;
          rx_d    = 8'h00;
          mosi_d  = pick_byte[0];
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = CW'(CLK_DIV - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d = CW'(CLK_DIV - 1);
          if (!sck_q) begin
            sck_d       = 1'b1;
            rx_d[bit_q] = miso;
          end else begin
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = S_HOLD;
            end else begin
              bit_d  = bit_q + 3'd1;
              mosi_d = tx_q[bit_q + 3'd1];
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(1)) begin
          done_d = grant_q;
          pdo_d  = rx_q;
        end
        if (cnt_q == '0) begin
`ifdef SPI_RR_LOCK_EN
          if (lock[rr_q] && req[rr_q]) begin
            state_d = S_SETUP;
            cnt_d   = CW'(CLK_DIV - 1);
            bit_d   = 3'd0;
            tx_d    = own_byte;
            rx_d    = 8'h00;
            mosi_d  = own_byte[0];
          end else begin
            state_d = S_GAP;
            cnt_d   = CW'(CS_GAP - 1);
            cs_n_d  = '1;
            grant_d = '0;
          end
`else
          state_d = S_GAP;
          cnt_d   = CW'(CS_GAP - 1);
          cs_n_d  = '1;
          grant_d = '0;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      rr_q    <= IW'(N - 1);
      grant_q <= '0;
      done_q  <= '0;
      pdo_q   <= 8'h00;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= '1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      pdo_q   <= pdo_d;
      busy_q  <= busy_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign p_data_out = pdo_q;
  assign busy       = busy_q;
  assign sck        = sck_q;
  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_rr_master.sv
// Directed self-checking bench for spi_rr_master (N=4, CLK_DIV=2, CS_GAP=2).
// Burst expectations follow SPI_RR_LOCK_EN when it is defined.
module tb_spi_rr_master;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [31:0]  p_data_in = '0;
  logic [3:0]   lock = '0;
  logic [3:0]   grant, done, cs_n;
  logic [7:0]   p_data_out;
  logic         busy, sck, mosi, miso;
  logic         loop = 1'b1;
  logic         miso_drv = 1'b0;
  logic [7:0]   pat = 8'h00;

  int nchk = 0;
  int nfail = 0;

  assign miso = loop ? mosi : miso_drv;

  spi_rr_master #(.N(4), .CLK_DIV(2), .CS_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .p_data_in(p_data_in), .lock(lock),
    .grant(grant), .done(done), .p_data_out(p_data_out), .busy(busy),
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_grant(output int w);
    w = 0;
    while (grant == 4'b0000 && w < 300) begin
      step(1);
      w++;
    end
  endtask

  // drop_at: 0 = requester drops req on done, -1 = never, k>0 = k cycles after grant
  task automatic run_xfer(input int drop_at, output int g, output int dat,
                          output logic [7:0] ms, output logic csok,
                          output logic [7:0] pdo_v, output logic [3:0] done_v,
                          output int nr, output int nf,
                          output logic [3:0] cs_after, output logic [3:0] gr_after);
    logic [3:0] expcs;
    logic       prev;
    g = -1;
    for (int i = 0; i < N; i++) if (grant[i]) g = i;
    expcs = ~grant;
    dat = -1; ms = '0; csok = 1'b1; pdo_v = '0; done_v = '0; nr = 0; nf = 0;
    miso_drv = pat[0];
    for (int k = 1; k <= 60; k++) begin
      prev = sck;
      step(1);
      if (sck && !prev) begin
        if (nr < 8) ms[nr] = mosi;
        nr++;
      end
      if (!sck && prev) begin
        nf++;
        if (nr < 8) miso_drv = pat[nr];
      end
      if (cs_n !== expcs) csok = 1'b0;
      if (k == drop_at && g >= 0) req[g] = 1'b0;
      if (done !== 4'b0000) begin
        dat = k; pdo_v = p_data_out; done_v = done;
        if (drop_at == 0 && g >= 0) req[g] = 1'b0;
        break;
      end
    end
    step(1);
    cs_after = cs_n;
    gr_after = grant;
  endtask

  initial begin
    int w, g, dat, nr, nf;
    logic [7:0] ms, pdo_v;
    logic       csok, prev;
    logic [3:0] done_v, cs_after, gr_after;

    // Reset values
    step(2);
    chk("rst_sck", sck, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_mosi", mosi, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_pdo", p_data_out, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Single transfer, loopback
    p_data_in[7:0] = 8'hA5;
    req = 4'b0001;
    wait_grant(w);
    chk("t1_latency", w, 1);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_cs", cs_n, 4'b1110);
    chk("t1_busy", busy, 1);
    chk("t1_mosi0", mosi, 1);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("t1_done_edge", dat, 35);
    chk("t1_done_vec", done_v, 4'b0001);
    chk("t1_mosi_seq", ms, 8'hA5);
    chk("t1_pdo", pdo_v, 8'hA5);
    chk("t1_cs_held", csok, 1);
    chk("t1_rises", nr, 8);
    chk("t1_cs_rel", cs_after, 4'hF);
    chk("t1_grant_rel", gr_after, 0);
    chk("t1_busy_gap", busy, 1);
    chk("t1_done_1cyc", done, 0);

    // Fairness from reset pointer
    do_reset();
    p_data_in = 32'h44332211;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(w);
      chk("fair_grant", grant, 32'(1) << i);
      if (i > 0) chk("fair_spacing", w, 3);
      run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
      chk("fair_pdo", pdo_v, p_data_in[8*i +: 8]);
    end
    req = 4'b0101;
    wait_grant(w);
    chk("fair2_first", grant, 4'b0001);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    wait_grant(w);
    chk("fair2_second", grant, 4'b0100);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);

    // MISO capture, slave drives 3C on falling edges
    loop = 1'b0;
    pat = 8'h3C;
    p_data_in[15:8] = 8'h00;
    req = 4'b0010;
    wait_grant(w);
    chk("miso_grant", grant, 4'b0010);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("miso_done", done_v, 4'b0010);
    chk("miso_pdo", pdo_v, 8'h3C);
    chk("miso_mosi", ms, 8'h00);
    loop = 1'b1;
    pat = 8'h00;

    // Late drop of req after grant
    p_data_in[23:16] = 8'h5A;
    req = 4'b0100;
    wait_grant(w);
    chk("drop_grant", grant, 4'b0100);
    run_xfer(3, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("drop_done_edge", dat, 35);
    chk("drop_done", done_v, 4'b0100);
    chk("drop_rises", nr, 8);
    chk("drop_falls", nf, 8);
    chk("drop_pdo", pdo_v, 8'h5A);

    // Async reset mid-SHIFT
    p_data_in[31:24] = 8'hFF;
    req = 4'b1000;
    wait_grant(w);
    chk("rstm_grant", grant, 4'b1000);
    nr = 0;
    for (int k = 0; k < 60 && nr < 4; k++) begin
      prev = sck;
      step(1);
      if (sck && !prev) nr++;
    end
    chk("rstm_rises", nr, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_sck", sck, 0);
    chk("rstm_cs", cs_n, 4'hF);
    chk("rstm_mosi", mosi, 0);
    chk("rstm_grant0", grant, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_pdo", p_data_out, 0);
    req = 4'b1001;
    step(3);
    chk("rstm_nodone", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(w);
    chk("rstm_next_grant", grant, 4'b0001);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("rstm_next_pdo", pdo_v, 8'h11);
    req = 4'b0000;

    // Burst request from requester 1 with requester 0 waiting
    p_data_in[7:0] = 8'hC3;
    p_data_in[15:8] = 8'h01;
    lock = 4'b0010;
    req = 4'b0011;
    wait_grant(w);
    chk("burst_grant1", grant, 4'b0010);
    p_data_in[15:8] = 8'h80;
    run_xfer(-1, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("burst_b1_pdo", pdo_v, 8'h01);
    chk("burst_b1_done", done_v, 4'b0010);
`ifdef SPI_RR_LOCK_EN
    chk("burst_cs_kept", cs_after, 4'b1101);
    chk("burst_grant_kept", gr_after, 4'b0010);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("burst_b2_cs", csok, 1);
    chk("burst_b2_pdo", pdo_v, 8'h80);
    chk("burst_b2_done", done_v, 4'b0010);
    wait_grant(w);
    chk("burst_then0", grant, 4'b0001);
    chk("burst_gap", w, 3);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("burst_r0_pdo", pdo_v, 8'hC3);
`else
    chk("nolock_cs_rel", cs_after, 4'hF);
    wait_grant(w);
    chk("nolock_grant0", grant, 4'b0001);
    chk("nolock_gap", w, 3);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("nolock_r0_pdo", pdo_v, 8'hC3);
    wait_grant(w);
    chk("nolock_grant1", grant, 4'b0010);
    run_xfer(0, g, dat, ms, csok, pdo_v, done_v, nr, nf, cs_after, gr_after);
    chk("nolock_b2_pdo", pdo_v, 8'h80);
`endif
    lock = '0;
    step(6);
    chk("end_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
